// File: rtl/sd_cmd_engine.sv
// SD native-mode CMD-line transactor: sends one 48-bit command frame with CRC7 and optionally
// collects a 48-bit or 136-bit response, checking CRC7/framing and timing out on Ncr.
module sd_cmd_engine #(
  parameter int unsigned CLK_HZ   = 100000000,
  parameter int unsigned SLOW_HZ  = 400000,
  parameter int unsigned FAST_HZ  = 25000000,
  parameter int unsigned NCR_MAX  = 64,
  parameter int unsigned NCC_BITS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   resp_type,
  input  logic         fast_mode,
  output logic         busy,
  output logic         done,
  output logic         timeout_err,
  output logic         crc_err,
  output logic [135:0] resp,
  output logic         sd_cclk,
  output logic         sd_cmd_out,
  output logic         sd_cmd_oe,
  input  logic         sd_cmd_in
);

  localparam int unsigned HalfSlow = CLK_HZ / (2 * SLOW_HZ);
  localparam int unsigned HalfFast = CLK_HZ / (2 * FAST_HZ);
  localparam logic [15:0] SlowM1   = 16'(HalfSlow - 1);
  localparam logic [15:0] FastM1   = 16'(HalfFast - 1);
  localparam logic [7:0]  NccLast  = 8'(NCC_BITS);
  localparam logic [7:0]  NcrLast  = 8'(NCR_MAX - 1);

  typedef enum logic [2:0] {
    StIdle, StNcc, StSend, StWait, StRecv, StCheck, StNrc, StDone
  } state_e;

  state_e         state_q;
  logic [15:0]    cnt_q;
  logic           cclk_q;
  logic           mode_q;
  logic [47:0]    frame_q;
  logic [7:0]     bit_cnt_q;
  logic [1:0]     type_q;
  logic [135:0]   resp_q;
  logic           busy_q, done_q, tout_q, crc_err_q, out_q, oe_q;

  logic [15:0]    half_m1;
  logic           tick, rise, fall;
  logic [7:0]     rx_last;
  logic [6:0]     crc_calc;
  logic           resp_bad;

  // CRC7 (x^7+x^3+1, init 0) over the low n bits of data, MSB first.
  function automatic logic [6:0] crc7_calc(input logic [119:0] data, input int n);
    logic [6:0] crc;
    logic       fb;
    crc = '0;
    for (int i = 119; i >= 0; i--) begin
      if (i < n) begin
        fb  = data[i] ^ crc[6];
        crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
      end
    end
    return crc;
  endfunction

  assign half_m1 = mode_q ? FastM1 : SlowM1;
  // >= so a switch to a shorter half period never overshoots the terminal count
  assign tick    = (cnt_q >= half_m1);
  assign rise    = tick & ~cclk_q;
  assign fall    = tick & cclk_q;
  assign rx_last = (type_q == 2'd2) ? 8'd135 : 8'd47;

  // Card-clock divider; free-runs, rate is re-latched only while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      cclk_q <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      if (!busy_q) mode_q <= fast_mode;
      if (tick) begin
        cnt_q  <= '0;
        cclk_q <= ~cclk_q;
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  // Response validation: CRC (type 1/2 only), transmission bit 0 and end bit 1.
  always_comb begin
    crc_calc = '0;
    resp_bad = 1'b0;
    if (type_q == 2'd2) begin
      crc_calc = crc7_calc(resp_q[127:8], 120);
      resp_bad = resp_q[134] | ~resp_q[0] | (crc_calc != resp_q[7:1]);
    end else begin
      crc_calc = crc7_calc({80'b0, resp_q[47:8]}, 40);
      resp_bad = resp_q[46] | ~resp_q[0] | ((type_q == 2'd1) && (crc_calc != resp_q[7:1]));
    end
  end

  // Transaction FSM; all pin-facing outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      type_q    <= '0;
      resp_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tout_q    <= 1'b0;
      crc_err_q <= 1'b0;
      out_q     <= 1'b1;
      oe_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            frame_q   <= {2'b01, cmd_index, cmd_arg,
                          crc7_calc({80'b0, 2'b01, cmd_index, cmd_arg}, 40), 1'b1};
            type_q    <= resp_type;
            resp_q    <= '0;
            tout_q    <= 1'b0;
            crc_err_q <= 1'b0;
            busy_q    <= 1'b1;
            oe_q      <= 1'b1;
            out_q     <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= StNcc;
          end
        end
        StNcc: begin
          // First falling edge opens the idle run; frame starts after NCC_BITS full clocks.
          if (fall) begin
            if (bit_cnt_q == NccLast) begin
              out_q     <= frame_q[47];
              frame_q   <= {frame_q[46:0], 1'b0};
              bit_cnt_q <= 8'd1;
              state_q   <= StSend;
            end else begin
              bit_cnt_q <= bit_cnt_q + 8'd1;
            end
          end
        end
        StSend: begin
          if (fall) begin
            if (bit_cnt_q == 8'd48) begin
              oe_q      <= 1'b0;
              out_q     <= 1'b1;
              bit_cnt_q <= '0;
              state_q   <= (type_q == 2'd0) ? StNrc : StWait;
            end else begin
              out_q     <= frame_q[47];
              frame_q   <= {frame_q[46:0], 1'b0};
              bit_cnt_q <= bit_cnt_q + 8'd1;
            end
          end
        end
        StWait: begin
          if (rise) begin
            if (!sd_cmd_in) begin
              resp_q    <= {resp_q[134:0], 1'b0};
              bit_cnt_q <= 8'd1;
              state_q   <= StRecv;
            end else if (bit_cnt_q == NcrLast) begin
              tout_q    <= 1'b1;
              bit_cnt_q <= '0;
              state_q   <= StNrc;
            end else begin
              bit_cnt_q <= bit_cnt_q + 8'd1;
            end
          end
        end
        StRecv: begin
          if (rise) begin
            resp_q <= {resp_q[134:0], sd_cmd_in};
            if (bit_cnt_q == rx_last) begin
              bit_cnt_q <= '0;
              state_q   <= StCheck;
            end else begin
              bit_cnt_q <= bit_cnt_q + 8'd1;
            end
          end
        end
        StCheck: begin
          crc_err_q <= resp_bad;
          state_q   <= StNrc;
        end
        StNrc: begin
          if (rise) begin
            if (bit_cnt_q == 8'd7) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StDone;
            end else begin
              bit_cnt_q <= bit_cnt_q + 8'd1;
            end
          end
        end
        StDone: begin
          // start coinciding with done is dropped here
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = tout_q;
  assign crc_err     = crc_err_q;
  assign resp        = resp_q;
  assign sd_cclk     = cclk_q;
  assign sd_cmd_out  = out_q;
  assign sd_cmd_oe   = oe_q;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Bench for sd_cmd_engine: SD card model on the CMD line, reference CRC7 by polynomial division.
module tb_sd_cmd_engine;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [5:0]   cmd_index = '0;
  logic [31:0]  cmd_arg = '0;
  logic [1:0]   resp_type = '0;
  logic         fast_mode = 1'b0;
  logic         sd_cmd_in = 1'b1;
  logic         busy, done, timeout_err, crc_err, sd_cclk, sd_cmd_out, sd_cmd_oe;
  logic [135:0] resp;

  // Slow rate raised so slow-mode transactions stay short (half period 4 cycles).
  sd_cmd_engine #(
    .CLK_HZ  (100000000),
    .SLOW_HZ (12500000),
    .FAST_HZ (25000000),
    .NCR_MAX (64),
    .NCC_BITS(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cmd_index  (cmd_index),
    .cmd_arg    (cmd_arg),
    .resp_type  (resp_type),
    .fast_mode  (fast_mode),
    .busy       (busy),
    .done       (done),
    .timeout_err(timeout_err),
    .crc_err    (crc_err),
    .resp       (resp),
    .sd_cclk    (sd_cclk),
    .sd_cmd_out (sd_cmd_out),
    .sd_cmd_oe  (sd_cmd_oe),
    .sd_cmd_in  (sd_cmd_in)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Card / line monitor state
  logic         prev_cclk = 1'b0;
  logic         tx_log[$];
  int           wait_rises = 0, card_len = 0, card_delay = 0, card_pos = 0, done_cnt = 0;
  int           run_len = 0, last_hi = 0, last_lo = 0;
  bit           card_en = 1'b0;
  logic [135:0] card_resp = '0;

  // Remainder of data(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] ref_crc7(input logic [135:0] data, input int n);
    logic [142:0] v, p;
    v = {data, 7'b0};
    p = 143'h89;
    for (int i = n + 6; i >= 7; i--) if (v[i]) v = v ^ (p << (i - 7));
    return v[6:0];
  endfunction

  function automatic logic [47:0] ref_frame(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, ref_crc7({96'b0, 2'b01, idx, arg}, 40), 1'b1};
  endfunction

  // Card side: host bits captured on rising edges while driven; card drives on falling edges.
  always @(negedge clk) begin
    if (sd_cclk && !prev_cclk) begin
      if (sd_cmd_oe) tx_log.push_back(sd_cmd_out);
      else if (busy || done) wait_rises++;
    end
    if (!sd_cclk && prev_cclk && card_en && !sd_cmd_oe && busy && wait_rises >= card_delay) begin
      if (card_pos < card_len) begin
        sd_cmd_in = card_resp[card_len - 1 - card_pos];
        card_pos++;
      end else begin
        sd_cmd_in = 1'b1;
        card_en = 1'b0;
      end
    end
    if (sd_cclk == prev_cclk) run_len++;
    else begin
      if (prev_cclk) last_hi = run_len;
      else last_lo = run_len;
      run_len = 1;
    end
    if (done) done_cnt++;
    prev_cclk = sd_cclk;
  end

  task automatic get_frame(output int lead, output logic [47:0] fr, output int total);
    lead = -1;
    fr = '0;
    total = tx_log.size();
    for (int i = 0; i < tx_log.size(); i++) begin
      if (tx_log[i] == 1'b0) begin
        lead = i;
        break;
      end
    end
    if (lead >= 0)
      for (int j = 0; j < 48; j++)
        if (lead + j < total) fr = {fr[46:0], tx_log[lead + j]};
  endtask

  task automatic clear_logs();
    tx_log.delete();
    wait_rises = 0;
    done_cnt = 0;
    card_pos = 0;
    sd_cmd_in = 1'b1;
  endtask

  task automatic wait_done(output logic ok);
    int cyc = 0;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    ok = done;
  endtask

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                         input logic fm, output logic ok);
    clear_logs();
    @(negedge clk);
    cmd_index = idx; cmd_arg = arg; resp_type = rt; fast_mode = fm; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(ok);
    repeat (40) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(negedge clk);
    tests_run += 7;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", done); end
    if ({timeout_err, crc_err} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_err got %b want 00", {timeout_err, crc_err});
    end
    if (resp !== '0) begin tests_failed++; $display("FAIL reset_resp got %h want 0", resp); end
    if (sd_cclk !== 1'b0) begin tests_failed++; $display("FAIL reset_cclk got %b", sd_cclk); end
    if (sd_cmd_out !== 1'b1) begin tests_failed++; $display("FAIL reset_out got %b", sd_cmd_out); end
    if (sd_cmd_oe !== 1'b0) begin tests_failed++; $display("FAIL reset_oe got %b", sd_cmd_oe); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_cmd0();
    logic ok; int lead, total; logic [47:0] fr;
    card_en = 1'b0;
    run_cmd(6'd0, 32'h0, 2'd0, 1'b0, ok);
    get_frame(lead, fr, total);
    tests_run += 7;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL cmd0_done_timeout got %b want 1", ok); end
    if (lead < 8 || lead > 9) begin tests_failed++; $display("FAIL cmd0_ncc got %0d want 8..9", lead); end
    if (total != lead + 48) begin
      tests_failed++; $display("FAIL cmd0_len got %0d want %0d", total, lead + 48);
    end
    if (fr !== 48'h400000000095) begin
      tests_failed++; $display("FAIL cmd0_frame got %h want 400000000095", fr);
    end
    if (done_cnt != 1) begin tests_failed++; $display("FAIL cmd0_done_cnt got %0d want 1", done_cnt); end
    if (timeout_err !== 1'b0) begin tests_failed++; $display("FAIL cmd0_tout got %b", timeout_err); end
    if (crc_err !== 1'b0) begin tests_failed++; $display("FAIL cmd0_crc got %b want 0", crc_err); end
  endtask

  task automatic test_cmd8();
    logic ok; int lead, total; logic [47:0] fr;
    card_resp = {88'b0, 48'h08000001AA13};
    card_len = 48;
    card_delay = $urandom_range(0, 20);
    card_en = 1'b1;
    run_cmd(6'd8, 32'h1AA, 2'd1, 1'b0, ok);
    get_frame(lead, fr, total);
    tests_run += 5;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL cmd8_done_timeout got %b want 1", ok); end
    if (fr !== 48'h48000001AA87) begin
      tests_failed++; $display("FAIL cmd8_frame got %h want 48000001AA87", fr);
    end
    if (resp !== 136'h08000001AA13) begin
      tests_failed++; $display("FAIL cmd8_resp got %h want 08000001AA13", resp);
    end
    if (crc_err !== 1'b0) begin tests_failed++; $display("FAIL cmd8_crc got %b want 0", crc_err); end
    if (timeout_err !== 1'b0) begin tests_failed++; $display("FAIL cmd8_tout got %b", timeout_err); end
  endtask

  task automatic test_timeout();
    logic ok;
    card_en = 1'b0;
    run_cmd(6'd17, $urandom, 2'd1, 1'b0, ok);
    tests_run += 6;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL tout_done_timeout got %b want 1", ok); end
    if (timeout_err !== 1'b1) begin tests_failed++; $display("FAIL tout_flag got %b want 1", timeout_err); end
    if (crc_err !== 1'b0) begin tests_failed++; $display("FAIL tout_crc got %b want 0", crc_err); end
    if (resp !== '0) begin tests_failed++; $display("FAIL tout_resp got %h want 0", resp); end
    // 64 waiting edges, then 8 Nrc edges up to done
    if (wait_rises != 72) begin
      tests_failed++; $display("FAIL tout_edges got %0d want 72", wait_rises);
    end
    if (done_cnt != 1) begin tests_failed++; $display("FAIL tout_done_cnt got %0d want 1", done_cnt); end
  endtask

  task automatic test_r2();
    logic ok; logic [119:0] payload; logic [135:0] good, bad, one;
    payload = {$urandom, $urandom, $urandom, 24'($urandom)};
    good = {2'b00, 6'h3F, payload, ref_crc7({16'b0, payload}, 120), 1'b1};
    one = 136'd1;
    bad = good ^ (one << $urandom_range(1, 7));
    card_resp = bad; card_len = 136; card_delay = $urandom_range(0, 10); card_en = 1'b1;
    run_cmd(6'd2, 32'h0, 2'd2, 1'b0, ok);
    tests_run += 3;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL r2bad_done_timeout got %b", ok); end
    if (crc_err !== 1'b1) begin tests_failed++; $display("FAIL r2bad_crc got %b want 1", crc_err); end
    if (resp !== bad) begin tests_failed++; $display("FAIL r2bad_resp got %h want %h", resp, bad); end
    card_resp = good; card_delay = $urandom_range(0, 10); card_en = 1'b1;
    run_cmd(6'd9, $urandom, 2'd2, 1'b0, ok);
    tests_run += 4;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL r2_done_timeout got %b", ok); end
    if (crc_err !== 1'b0) begin tests_failed++; $display("FAIL r2_crc got %b want 0", crc_err); end
    if (timeout_err !== 1'b0) begin tests_failed++; $display("FAIL r2_tout got %b", timeout_err); end
    if (resp !== good) begin tests_failed++; $display("FAIL r2_resp got %h want %h", resp, good); end
  endtask

  task automatic test_random();
    logic ok; int lead, total; logic [47:0] fr, r, one; logic [5:0] idx; logic [31:0] arg;
    logic [1:0] rt; logic fm, exp_err; int c;
    one = 48'd1;
    for (int it = 0; it < 10; it++) begin
      idx = 6'($urandom); arg = $urandom; fm = 1'($urandom);
      rt = ($urandom_range(0, 1) == 0) ? 2'd1 : 2'd3;
      r = {2'b00, 6'($urandom), $urandom, 7'd0, 1'b1};
      r[7:1] = (rt == 2'd1) ? ref_crc7({96'b0, r[47:8]}, 40) : 7'($urandom);
      c = $urandom_range(0, 3);
      if (c == 1) r = r ^ (one << $urandom_range(1, 7));
      if (c == 2) r[0] = 1'b0;
      if (c == 3) r[46] = 1'b1;
      exp_err = !r[0] || r[46] || (rt == 2'd1 && r[7:1] != ref_crc7({96'b0, r[47:8]}, 40));
      card_resp = {88'b0, r}; card_len = 48; card_delay = $urandom_range(0, 30); card_en = 1'b1;
      run_cmd(idx, arg, rt, fm, ok);
      get_frame(lead, fr, total);
      tests_run += 5;
      if (ok !== 1'b1) begin tests_failed++; $display("FAIL rnd%0d_done_timeout got %b", it, ok); end
      if (fr !== ref_frame(idx, arg)) begin
        tests_failed++; $display("FAIL rnd%0d_frame got %h want %h", it, fr, ref_frame(idx, arg));
      end
      if (resp !== {88'b0, r}) begin
        tests_failed++; $display("FAIL rnd%0d_resp got %h want %h", it, resp, r);
      end
      if (crc_err !== exp_err) begin
        tests_failed++; $display("FAIL rnd%0d_crc got %b want %b", it, crc_err, exp_err);
      end
      if (timeout_err !== 1'b0) begin
        tests_failed++; $display("FAIL rnd%0d_tout got %b want 0", it, timeout_err);
      end
    end
  endtask

  task automatic test_fast();
    logic ok; int lead, total; logic [47:0] fr; logic [31:0] arg;
    card_en = 1'b0;
    arg = $urandom;
    clear_logs();
    @(negedge clk);
    cmd_index = 6'd55; cmd_arg = arg; resp_type = 2'd0; fast_mode = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    tests_run += 2;
    if (last_hi != 2) begin tests_failed++; $display("FAIL fast_high got %0d want 2", last_hi); end
    if (last_lo != 2) begin tests_failed++; $display("FAIL fast_low got %0d want 2", last_lo); end
    cmd_index = 6'd12; cmd_arg = ~arg; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests_run += 1;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL fast_busy got %b want 1", busy); end
    wait_done(ok);
    repeat (60) @(negedge clk);
    get_frame(lead, fr, total);
    tests_run += 4;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL fast_done_timeout got %b", ok); end
    if (fr !== ref_frame(6'd55, arg)) begin
      tests_failed++; $display("FAIL fast_frame got %h want %h", fr, ref_frame(6'd55, arg));
    end
    if (total != lead + 48) begin
      tests_failed++; $display("FAIL fast_len got %0d want %0d", total, lead + 48);
    end
    if (done_cnt != 1) begin tests_failed++; $display("FAIL fast_done_cnt got %0d want 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    logic ok; int lead, total; logic [47:0] fr; logic [31:0] arg;
    card_en = 1'b0;
    arg = $urandom;
    clear_logs();
    @(negedge clk);
    cmd_index = 6'd3; cmd_arg = $urandom; resp_type = 2'd0; fast_mode = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(ok);
    cmd_index = 6'd7; cmd_arg = arg; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests_run += 2;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL b2b_done_timeout got %b", ok); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_start_on_done got busy %b want 0", busy); end
    tx_log.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests_run += 1;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_accept got busy %b want 1", busy); end
    wait_done(ok);
    repeat (40) @(negedge clk);
    get_frame(lead, fr, total);
    tests_run += 2;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL b2b_done2_timeout got %b", ok); end
    if (fr !== ref_frame(6'd7, arg)) begin
      tests_failed++; $display("FAIL b2b_frame got %h want %h", fr, ref_frame(6'd7, arg));
    end
  endtask

  task automatic test_reset_mid();
    logic ok; int lead, total, cyc; logic [47:0] fr; logic [31:0] arg;
    card_en = 1'b0;
    clear_logs();
    @(negedge clk);
    cmd_index = 6'd24; cmd_arg = $urandom; resp_type = 2'd1; fast_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (tx_log.size() < 29 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run += 5;
    if (cyc >= 5000) begin tests_failed++; $display("FAIL rstmid_reach_send got %0d bits", tx_log.size()); end
    if (sd_cmd_oe !== 1'b0) begin tests_failed++; $display("FAIL rstmid_oe got %b want 0", sd_cmd_oe); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy got %b want 0", busy); end
    if (sd_cmd_out !== 1'b1) begin tests_failed++; $display("FAIL rstmid_out got %b", sd_cmd_out); end
    if (done !== 1'b0) begin tests_failed++; $display("FAIL rstmid_done got %b want 0", done); end
    repeat (300) @(negedge clk);
    tests_run += 1;
    if (done_cnt != 0) begin tests_failed++; $display("FAIL rstmid_no_done got %0d want 0", done_cnt); end
    arg = $urandom;
    run_cmd(6'd13, arg, 2'd0, 1'b0, ok);
    get_frame(lead, fr, total);
    tests_run += 3;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL rstmid_after_timeout got %b", ok); end
    if (lead < 8 || lead > 9) begin tests_failed++; $display("FAIL rstmid_ncc got %0d", lead); end
    if (fr !== ref_frame(6'd13, arg)) begin
      tests_failed++; $display("FAIL rstmid_frame got %h want %h", fr, ref_frame(6'd13, arg));
    end
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_cmd8();
    test_timeout();
    test_r2();
    test_random();
    test_fast();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
